// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  localparam int unsigned DEFAULT_DEPTH = 1024;
  localparam int unsigned DEFAULT_AW    = 10;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Loads a length-prefixed program image into instruction memory, verifies its
// XOR checksum and releases the core only after a clean load.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_start,
  input  logic          s_valid,
  input  logic [31:0]   s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   pc_in,
  output logic [31:0]   mem_raddr,
  output logic          imem_rst_n,
  output logic          core_run,
  output logic          busy,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [AW:0]   words_loaded
);

  state_t        state;
  logic [AW:0]   len;
  logic [AW:0]   len_m1;
  logic [AW-1:0] ptr;
  logic [31:0]   csum;
  logic          len_bad;

  assign len_m1  = len - (AW+1)'(1);
  assign len_bad = (s_data == 32'd0) || (s_data > 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      len          <= '0;
      ptr          <= '0;
      csum         <= '0;
      words_loaded <= '0;
      err_code     <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (boot_start) begin
            state    <= S_HDR;
            err_code <= ERR_NONE;
          end
        end
        S_HDR: begin
          if (s_valid) begin
            if (len_bad) begin
              state    <= S_ERR;
              err_code <= ERR_LEN;
            end else begin
              len          <= s_data[AW:0];
              ptr          <= '0;
              csum         <= '0;
              words_loaded <= '0;
              state        <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            csum         <= csum ^ s_data;
            // ptr may wrap to 0 after the last word of a full-depth image; no write follows.
            ptr          <= ptr + AW'(1);
            words_loaded <= words_loaded + (AW+1)'(1);
            if ({1'b0, ptr} == len_m1) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (s_valid) begin
            if (s_data == csum) begin
              state <= S_RUN;
            end else begin
              state    <= S_ERR;
              err_code <= ERR_CSUM;
            end
          end
        end
        S_RUN, S_ERR: begin
          if (boot_start) begin
            state    <= S_HDR;
            err_code <= ERR_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready    = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
    busy       = s_ready;
    error      = (state == S_ERR);
    core_run   = (state == S_RUN);
    imem_rst_n = core_run;
    mem_raddr  = core_run ? pc_in : '0;
    mem_we     = (state == S_LOAD) && s_valid;
    mem_waddr  = (state == S_LOAD) ? ptr : '0;
    mem_wdata  = (state == S_LOAD) ? s_data : '0;
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected writes and load outcomes are
// queued by the stimulus and popped by an independent monitor.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        boot_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] pc_in = '0;
  logic [31:0] mem_raddr;
  logic        imem_rst_n;
  logic        core_run;
  logic        busy;
  logic        error;
  logic [1:0]  err_code;
  logic [10:0] words_loaded;

  imem_boot_ctrl #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .pc_in(pc_in), .mem_raddr(mem_raddr), .imem_rst_n(imem_rst_n),
    .core_run(core_run), .busy(busy), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic err; logic [1:0] code; logic [10:0] wl; } outc_t;

  wr_t         wq[$];
  outc_t       oq[$];
  logic [31:0] img[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          t0;
  logic        prev_run = 1'b0;
  logic        prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", nm, $time);
  endtask

  // Monitor: every write must match the oldest queued write; every RUN/ERR entry
  // must match the oldest queued outcome.
  always @(negedge clk) begin
    wr_t   w;
    outc_t o;
    if (mem_we) begin
      if (wq.size() == 0) fail_now("spurious_mem_we");
      else begin
        w = wq.pop_front();
        chk("mem_waddr", 32'(mem_waddr), 32'(w.a));
        chk("mem_wdata", mem_wdata, w.d);
      end
    end
    if ((core_run && !prev_run) || (error && !prev_err)) begin
      if (oq.size() == 0) fail_now("unexpected_outcome");
      else begin
        o = oq.pop_front();
        chk("outcome_error", 32'(error), 32'(o.err));
        chk("outcome_run", 32'(core_run), 32'(!o.err));
        chk("outcome_err_code", 32'(err_code), 32'(o.code));
        chk("outcome_words_loaded", 32'(words_loaded), 32'(o.wl));
        chk("outcome_imem_rst_n", 32'(imem_rst_n), 32'(!o.err));
        chk("outcome_busy", 32'(busy), 32'd0);
      end
    end
    prev_run <= core_run;
    prev_err <= error;
  end

  task automatic send_word(input logic [31:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 20 && !s_ready; t++) begin
      @(posedge clk); #1;
    end
    if (!s_ready) fail_now("s_ready_timeout");
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic pulse_boot();
    boot_start = 1'b1;
    @(posedge clk); #1;
    boot_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic load(input logic [31:0] n, input logic [31:0] cs, input int gap);
    bit  legal;
    wr_t w;
    legal = (n != 32'd0) && (n <= 32'd1024);
    if (legal) begin
      for (int i = 0; i < img.size(); i++) begin
        w.a = 10'(i);
        w.d = img[i];
        wq.push_back(w);
      end
    end
    send_word(n, 0);
    if (legal) begin
      for (int i = 0; i < img.size(); i++) send_word(img[i], (gap > 0) ? ((i % 3) + 1) : 0);
      send_word(cs, gap);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && !(core_run || error); i++) begin
      @(posedge clk); #1;
    end
    if (!(core_run || error)) fail_now("done_timeout");
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_core_run"}, 32'(core_run), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_imem_rst_n"}, 32'(imem_rst_n), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    chk({tag, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_raddr"}, mem_raddr, 32'd0);
  endtask

  initial begin
    logic [31:0] cs;
    logic [31:0] pcs [3];
    pcs[0] = 32'h0000_0000; pcs[1] = 32'h0000_0004; pcs[2] = 32'h0000_0FFC;

    // Reset with busy-looking inputs must still give all-zero outputs.
    rst = 1'b0; s_valid = 1'b1; s_data = 32'hFFFF_FFFF; pc_in = 32'h0000_0100;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    s_valid = 1'b0; s_data = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_mem_raddr", mem_raddr, 32'd0);

    // Good load: 3 words, checksum 0x00D08033, RUN 5 cycles after HDR entry.
    img = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
    oq.push_back(outc_t'{err: 1'b0, code: 2'd0, wl: 11'd3});
    pulse_boot();
    chk("hdr_busy", 32'(busy), 32'd1);
    load(32'd3, 32'h00D0_8033, 0);
    wait_done();
    chk("load_cycles", 32'(cyc - t0), 32'd5);
    for (int i = 0; i < 3; i++) begin
      pc_in = pcs[i];
      #1;
      chk("mem_raddr_run", mem_raddr, pcs[i]);
    end

    // Reboot from RUN, then a bad checksum.
    pc_in = 32'h0000_0040;
    pulse_boot();
    chk("reboot_core_run", 32'(core_run), 32'd0);
    chk("reboot_busy", 32'(busy), 32'd1);
    chk("reboot_mem_raddr", mem_raddr, 32'd0);
    oq.push_back(outc_t'{err: 1'b1, code: 2'd2, wl: 11'd3});
    load(32'd3, 32'h00D0_8032, 0);
    wait_done();
    chk("csum_err_core_run", 32'(core_run), 32'd0);
    chk("csum_err_imem_rst_n", 32'(imem_rst_n), 32'd0);

    // Reboot from ERR clears err_code; length 0 and DEPTH+1 are rejected.
    pulse_boot();
    chk("err_reboot_err_code", 32'(err_code), 32'd0);
    chk("err_reboot_error", 32'(error), 32'd0);
    chk("err_reboot_busy", 32'(busy), 32'd1);
    oq.push_back(outc_t'{err: 1'b1, code: 2'd1, wl: 11'd3});
    load(32'd0, 32'd0, 0);
    wait_done();
    pulse_boot();
    oq.push_back(outc_t'{err: 1'b1, code: 2'd1, wl: 11'd3});
    load(32'd1025, 32'd0, 0);
    wait_done();
    chk("len_err_mem_raddr", mem_raddr, 32'd0);

    // Stream gaps: identical writes and outcome to the good load.
    pulse_boot();
    oq.push_back(outc_t'{err: 1'b0, code: 2'd0, wl: 11'd3});
    load(32'd3, 32'h00D0_8033, 2);
    wait_done();

    // Reset mid-load after two data words.
    pulse_boot();
    wq.push_back(wr_t'{a: 10'd0, d: 32'h0050_0093});
    wq.push_back(wr_t'{a: 10'd1, d: 32'h00A0_0113});
    send_word(32'd3, 0);
    send_word(32'h0050_0093, 0);
    send_word(32'h00A0_0113, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_quiet("midreset");
    rst = 1'b1;
    @(posedge clk); #1;
    img = '{32'h1111_1111, 32'h2222_2222};
    pulse_boot();
    oq.push_back(outc_t'{err: 1'b0, code: 2'd0, wl: 11'd2});
    load(32'd2, 32'h3333_3333, 0);
    wait_done();

    // Full-depth image: every address 0..1023 written once, no wrap.
    img.delete();
    cs = '0;
    for (int i = 0; i < 1024; i++) begin
      img.push_back((32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);
      cs = cs ^ img[i];
    end
    pulse_boot();
    oq.push_back(outc_t'{err: 1'b0, code: 2'd0, wl: 11'd1024});
    load(32'd1024, cs, 0);
    wait_done();
    pc_in = 32'h0000_0FFC;
    #1;
    chk("full_mem_raddr", mem_raddr, 32'h0000_0FFC);

    repeat (3) @(posedge clk);
    #1;
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("outcomes_drained", 32'(oq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
